// File: rtl/masked_trace_sequencer.sv
// masked_trace_sequencer
//   Acquisition sequencer for a masked two-gate gadget. For each trace it
//   drives a stimulus {r2,r1,b,a}, pulses a scope trigger, holds the stimulus
//   for a settle window, captures the gadget output and offers it to a
//   logging consumer over valid/ready. Supports fixed, random and
//   fixed-vs-random interleaved data selection.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, abort  run control (start sampled only in IDLE)
//   mode          00 fixed, 01 random, 10 interleaved, 11 random
//   fixed_ab      fixed data value {b,a}
//   dut_in        gadget stimulus: bit0 a, bit1 b, bit2 r1, bit3 r2
//   dut_out       gadget output
//   trigger       one-cycle scope trigger
//   cap_valid/cap_ready/cap_data/cap_in/cap_class  captured sample handshake
//   trace_cnt     traces accepted in the current run
//   busy, done    run status (done is a one-cycle pulse)

module masked_trace_sequencer #(
  parameter int unsigned OUT_SIZE      = 1,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_TRACES    = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [1:0]          fixed_ab,
  output logic [3:0]          dut_in,
  input  logic [OUT_SIZE-1:0] dut_out,
  output logic                trigger,
  output logic                cap_valid,
  input  logic                cap_ready,
  output logic [OUT_SIZE-1:0] cap_data,
  output logic [3:0]          cap_in,
  output logic                cap_class,
  output logic [15:0]         trace_cnt,
  output logic                busy,
  output logic                done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LAST_CNT    = 16'(NUM_TRACES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [7:0]  settle_cnt;
  logic        cls_reg;
  logic        stim_cls;
  logic [1:0]  stim_ab;
  logic [3:0]  stim;
  logic [15:0] cnt_inc;

  // Next LFSR value: 16-bit Fibonacci, right shift, taps 0/2/3/5.
  always_comb begin
    lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Stimulus selection from the stepped LFSR; class 1 means fixed data.
  always_comb begin
    stim_cls = 1'b0;
    case (mode)
      2'b00:   stim_cls = 1'b1;
      2'b10:   stim_cls = lfsr_next[15];
      default: stim_cls = 1'b0;
    endcase
    stim_ab = stim_cls ? fixed_ab : lfsr_next[1:0];
    stim    = {lfsr_next[3], lfsr_next[2], stim_ab};
  end

  assign cnt_inc = trace_cnt + 16'd1;
  assign busy    = (state != S_IDLE);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      settle_cnt <= 8'd0;
      cls_reg    <= 1'b0;
      dut_in     <= 4'd0;
      trigger    <= 1'b0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      cap_in     <= 4'd0;
      cap_class  <= 1'b0;
      trace_cnt  <= 16'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over everything, including a same-cycle cap_ready.
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        cap_valid <= 1'b0;
        trigger   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // A start coinciding with the done pulse is ignored.
            if (start && !done) begin
              trace_cnt <= 16'd0;
              state     <= S_LOAD;
            end
          end
          S_LOAD: begin
            lfsr       <= lfsr_next;
            dut_in     <= stim;
            cls_reg    <= stim_cls;
            trigger    <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
          S_SETTLE: begin
            trigger <= 1'b0;
            if (settle_cnt == 8'd0) begin
              state <= S_CAPTURE;
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end
          S_CAPTURE: begin
            cap_data  <= dut_out;
            cap_in    <= dut_in;
            cap_class <= cls_reg;
            cap_valid <= 1'b1;
            state     <= S_ACK;
          end
          S_ACK: begin
            if (cap_ready) begin
              cap_valid <= 1'b0;
              trace_cnt <= cnt_inc;
              if (cnt_inc == LAST_CNT) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                state <= S_LOAD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_masked_trace_sequencer.sv
// tb_masked_trace_sequencer
//   Directed bench for masked_trace_sequencer with a scoreboard of expected
//   captures and a small behavioural gadget driving dut_out.

module tb_masked_trace_sequencer;

  localparam int unsigned OUT_SIZE = 1;
  localparam int unsigned SETTLE   = 4;
  localparam int unsigned NT       = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [1:0]          mode = 2'b01;
  logic [1:0]          fixed_ab = 2'b00;
  logic [3:0]          dut_in;
  logic [OUT_SIZE-1:0] dut_out;
  logic                trigger;
  logic                cap_valid;
  logic                cap_ready = 1'b1;
  logic [OUT_SIZE-1:0] cap_data;
  logic [3:0]          cap_in;
  logic                cap_class;
  logic [15:0]         trace_cnt;
  logic                busy;
  logic                done;

  typedef struct packed {
    logic [3:0] stim;
    logic       cls;
    logic       data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  int          checks = 0;
  int          failures = 0;
  int          n_fixed = 0;
  int          n_rand = 0;

  always #5 clk = ~clk;

  masked_trace_sequencer #(
    .OUT_SIZE(OUT_SIZE), .SETTLE_CYCLES(SETTLE), .NUM_TRACES(NT), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .fixed_ab(fixed_ab), .dut_in(dut_in), .dut_out(dut_out), .trigger(trigger),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
    .cap_in(cap_in), .cap_class(cap_class), .trace_cnt(trace_cnt),
    .busy(busy), .done(done)
  );

  // Behavioural gadget: y = (a & b) ^ r1 ^ r2.
  function automatic logic gadget(input logic [3:0] s);
    return (s[0] & s[1]) ^ s[2] ^ s[3];
  endfunction

  assign dut_out = gadget(dut_in);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = 1'b0;
    foreach (l[i]) if (i == 0 || i == 2 || i == 3 || i == 5) fb = fb ^ l[i];
    return {fb, l[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_cap_valid", 32'(cap_valid), 32'd0);
    chk("rst_cap_data", 32'(cap_data), 32'd0);
    chk("rst_cap_in", 32'(cap_in), 32'd0);
    chk("rst_cap_class", 32'(cap_class), 32'd0);
    chk("rst_trace_cnt", 32'(trace_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lfsr", 32'(u_dut.lfsr), 32'h0000ACE1);
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_cnt_clear", 32'(trace_cnt), 32'd0);
  endtask

  // Wait for the trigger of the next trace and push its expected capture.
  task automatic wait_load();
    int          n;
    exp_t        e;
    logic [15:0] nl;
    logic        c;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!trigger && n < 20);
    chk("trig_lat", 32'(n), 32'd1);
    nl     = lfsr_step(m_lfsr);
    m_lfsr = nl;
    case (mode)
      2'b00:   c = 1'b1;
      2'b10:   c = nl[15];
      default: c = 1'b0;
    endcase
    e.stim = {nl[3], nl[2], (c ? fixed_ab : nl[1:0])};
    e.cls  = c;
    e.data = gadget(e.stim);
    exp_q.push_back(e);
    chk("dut_in", 32'(dut_in), 32'(e.stim));
  endtask

  // Wait for cap_valid and compare against the oldest expected capture.
  task automatic wait_capture();
    int   n;
    exp_t e;
    @(posedge clk); #1;
    n = 1;
    chk("trig_pulse", 32'(trigger), 32'd0);
    while (!cap_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cap_lat", 32'(n), 32'(SETTLE + 1));
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("cap_in", 32'(cap_in), 32'(e.stim));
      chk("cap_class", 32'(cap_class), 32'(e.cls));
      chk("cap_data", 32'(cap_data), 32'(e.data));
      if (e.cls) n_fixed++; else n_rand++;
    end
  endtask

  // Optionally stall the consumer, then accept the sample.
  task automatic finish_ack(input int bp, input logic [15:0] exp_cnt);
    logic [3:0]          s_in;
    logic [OUT_SIZE-1:0] s_data;
    logic                s_cls;
    if (bp > 0) begin
      cap_ready = 1'b0;
      s_in   = cap_in;
      s_data = cap_data;
      s_cls  = cap_class;
      repeat (bp) begin
        @(posedge clk); #1;
        chk("bp_valid", 32'(cap_valid), 32'd1);
        chk("bp_cap_in", 32'(cap_in), 32'(s_in));
        chk("bp_cap_data", 32'(cap_data), 32'(s_data));
        chk("bp_cap_class", 32'(cap_class), 32'(s_cls));
        chk("bp_trigger", 32'(trigger), 32'd0);
        chk("bp_cnt", 32'(trace_cnt), 32'(exp_cnt - 16'd1));
      end
      cap_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("ack_valid", 32'(cap_valid), 32'd0);
    chk("ack_cnt", 32'(trace_cnt), 32'(exp_cnt));
    chk("ack_done", 32'(done), 32'(exp_cnt == 16'(NT)));
    chk("ack_busy", 32'(busy), 32'(exp_cnt != 16'(NT)));
  endtask

  task automatic run_traces(input int bp_idx);
    start_run();
    for (int i = 1; i <= int'(NT); i++) begin
      wait_load();
      wait_capture();
      finish_ack((i == bp_idx) ? 5 : 0, 16'(i));
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();

    // Random mode: first trace timing and known first LFSR step
    mode = 2'b01;
    start_run();
    wait_load();
    chk("lfsr_first", 32'(u_dut.lfsr), 32'h00005670);
    chk("dut_in_first", 32'(dut_in), 32'd0);
    wait_capture();
    finish_ack(0, 16'd1);
    for (int i = 2; i <= int'(NT); i++) begin
      wait_load();
      wait_capture();
      finish_ack(0, 16'(i));
    end
    // start coinciding with the done pulse must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_on_done", 32'(busy), 32'd0);
    chk("done_cleared", 32'(done), 32'd0);

    // Fixed mode
    mode = 2'b00;
    fixed_ab = 2'b11;
    n_fixed = 0;
    n_rand = 0;
    run_traces(0);
    idle_cycle();
    chk("fixed_all_cls1", 32'(n_fixed), 32'(NT));

    // Interleaved mode, 64 traces
    mode = 2'b10;
    fixed_ab = 2'b01;
    n_fixed = 0;
    n_rand = 0;
    for (int r = 0; r < 8; r++) begin
      run_traces(0);
      idle_cycle();
    end
    chk("tvla_total", 32'(n_fixed + n_rand), 32'd64);
    chk("tvla_both_classes", 32'((n_fixed > 0) && (n_rand > 0)), 32'd1);

    // Backpressure on trace 2
    mode = 2'b01;
    run_traces(2);
    idle_cycle();

    // Abort in SETTLE of trace 3
    start_run();
    for (int i = 1; i <= 2; i++) begin
      wait_load();
      wait_capture();
      finish_ack(0, 16'(i));
    end
    wait_load();
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(cap_valid), 32'd0);
    chk("abort_trigger", 32'(trigger), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", 32'(trace_cnt), 32'd2);
    chk("abort_lfsr_held", 32'(u_dut.lfsr), 32'(m_lfsr));
    void'(exp_q.pop_front());
    idle_cycle();
    run_traces(0);
    idle_cycle();

    // start while busy, then rst during a stalled ACK
    start_run();
    start = 1'b1;
    wait_load();
    wait_capture();
    finish_ack(0, 16'd1);
    wait_load();
    wait_capture();
    start = 1'b0;
    cap_ready = 1'b0;
    @(posedge clk); #1;
    chk("stall_valid", 32'(cap_valid), 32'd1);
    chk("busy_start_cnt", 32'(trace_cnt), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cap_ready = 1'b1;
    check_reset_state();
    exp_q.delete();
    m_lfsr = 16'hACE1;

    // After reset the LFSR restarts from the seed
    start_run();
    wait_load();
    chk("reseed_dut_in", 32'(dut_in), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/masked_trace_sequencer.md
Name: masked_trace_sequencer

Overview:
- Drives the 4-bit stimulus bus of the masked two-gate gadget under test: data shares a, b and fresh masks r1, r2.
- Runs a programmed number of acquisitions. For each one it applies a stimulus, raises a scope trigger, waits a settle window, captures the gadget output and hands it to the logging side over a valid/ready handshake.
- Stimulus can be fixed-data, random-data, or fixed-vs-random interleaved for TVLA.
- Sits between the testbench/acquisition harness and the gadget's `in`/`y` ports.

Parameters:
- OUT_SIZE, 1: gadget output width.
- SETTLE_CYCLES, 4: cycles the stimulus is held before capture; legal range 1..255.
- NUM_TRACES, 16: acquisitions per run; legal range 1..65535.
- LFSR_SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin run; sampled only in IDLE.
- abort  input  1  terminate run; state returns to IDLE at next edge.
- mode  input  2  00 fixed data, 01 random data, 10 interleaved, 11 treated as 01.
- fixed_ab  input  2  fixed data value {b,a}.
- dut_in  output  4  gadget stimulus: bit0 a, bit1 b, bit2 r1, bit3 r2.
- dut_out  input  OUT_SIZE  gadget output.
- trigger  output  1  scope trigger, one-cycle pulse.
- cap_valid  output  1  captured sample available.
- cap_ready  input  1  consumer accepts sample.
- cap_data  output  OUT_SIZE  captured dut_out.
- cap_in  output  4  stimulus that produced cap_data.
- cap_class  output  1  1 = fixed-class trace, 0 = random-class trace.
- trace_cnt  output  16  traces accepted in the current run.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset: state IDLE, lfsr = LFSR_SEED, and every output register = 0 (dut_in, trigger, cap_*, trace_cnt, done).
- LFSR: 16-bit Fibonacci, right shift. fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}. It steps exactly once per LOAD; "nl" below is its next value.
- Stimulus selection in LOAD:
  - Masks: r1 = nl[2], r2 = nl[3].
  - Data:
    - mode 00: {b,a} = fixed_ab, class = 1.
    - mode 01: {b,a} = nl[1:0], class = 0.
    - mode 10: class = nl[15]; data is fixed_ab if class = 1, else nl[1:0].
- FSM IDLE -> LOAD -> SETTLE -> CAPTURE -> ACK:
  - IDLE: on start, trace_cnt <= 0, go to LOAD.
  - LOAD (1 cycle): lfsr <= nl, dut_in <= stimulus, cls_reg <= class, trigger <= 1, settle_cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: trigger <= 0. If settle_cnt == 0 go to CAPTURE, else decrement. dut_in is stable for exactly SETTLE_CYCLES cycles, and trigger is high in the first of them.
  - CAPTURE (1 cycle): cap_data <= dut_out, cap_in <= dut_in, cap_class <= cls_reg, cap_valid <= 1, go to ACK.
  - ACK: hold all cap_* stable while cap_ready = 0. When cap_ready = 1:
    - cap_valid <= 0 and trace_cnt <= trace_cnt+1.
    - If trace_cnt+1 == NUM_TRACES: done <= 1 and go to IDLE. Otherwise go to LOAD.
- Latency:
  - start sampled at edge E0; dut_in and trigger change at E1.
  - Capture at E1+SETTLE_CYCLES+1. With cap_ready tied high, one trace takes SETTLE_CYCLES+3 cycles.
- Signals held between traces and after a run: dut_in holds its last value; trace_cnt and cap_data hold.
- Start handling: start while busy is ignored; start asserted with done is ignored.
- Abort (any non-IDLE state):
  - Next edge: state = IDLE, cap_valid = 0, trigger = 0, done stays 0.
  - dut_in, trace_cnt and lfsr hold, so the LFSR continues its sequence on the next run.
  - abort takes priority over cap_ready in the same cycle; that trace is not counted.
- rst mid-run: identical to reset, and the LFSR is reseeded.
- The 16-bit trace_cnt never wraps within the legal NUM_TRACES range.

Test Plan:
- Reset, seed ACE1, mode 01, NUM_TRACES 1, SETTLE 4, cap_ready=1 -> first LOAD gives lfsr=16'h5670 and dut_in=4'h0; trigger high exactly at E1; cap_valid high at E6; done pulses at E7; trace_cnt=1.
- mode 00, fixed_ab=2'b11, 8 traces -> every cap_in[1:0]=2'b11 and cap_class=1; cap_in[3:2] match a software model of the LFSR; done after 8 accepts.
- mode 10, 64 traces -> cap_class equals model nl[15] for each trace; fixed-class traces carry fixed_ab; both classes appear.
- Backpressure: cap_ready low for 5 cycles in ACK -> cap_valid, cap_data and cap_in stable; no new trigger; trace_cnt increments once after ready.
- abort asserted in SETTLE of trace 3 -> IDLE next cycle, no done, trace_cnt=2; a new start produces fresh trigger timing and an LFSR continuing from its held state.
- start asserted while busy, plus rst during ACK -> start has no effect; after rst every output is 0 and lfsr=ACE1.
